shared_adder_arbiter: RTL

SHARED_ADDER_ARBITER -- requirements
Module: shared_adder_arbiter

---
 rtl/shared_adder_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/shared_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : twenty_bit_adder
// Purpose  : Plain 20-bit unsigned adder with carry-out.
// Ports    : a_i, b_i   - 20-bit operands
//            sum_o      - low 20 bits of a_i + b_i
//            cout_o     - carry out of bit 19
// Revision : 1.0 - initial release
// ============================================================================
module twenty_bit_adder (
    input  logic [19:0] a_i,
    input  logic [19:0] b_i,
    output logic [19:0] sum_o,
    output logic        cout_o
);
    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};
endmodule

// ============================================================================
// Module   : shared_adder_arbiter
// Purpose  : Four requesters share one 20-bit adder through a round-robin
//            arbiter. One transaction is in flight at a time:
//            IDLE (grant + capture) -> CALC (add, register) -> RESP (hold).
// Ports    : clk, rst        - clock, synchronous active-high reset
//            req_valid[3:0]  - per-requester request
//            req_a/req_b     - packed operands, requester k at [20k+19:20k]
//            req_ready[3:0]  - one-hot grant, combinational in IDLE
//            resp_valid      - result available (RESP state)
//            resp_ready      - consumer accepts result
//            resp_sum/cout   - registered sum and carry-out
//            resp_id         - requester that owns the result
// Revision : 1.0 - initial release
// ============================================================================
module shared_adder_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req_valid,
    input  logic [79:0] req_a,
    input  logic [79:0] req_b,
    output logic [3:0]  req_ready,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [19:0] resp_sum,
    output logic        resp_cout,
    output logic [1:0]  resp_id
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [19:0] a_q, a_d;
    logic [19:0] b_q, b_d;
    logic [1:0]  id_q, id_d;
    logic [19:0] sum_q, sum_d;
    logic        cout_q, cout_d;
    logic [1:0]  rid_q, rid_d;

    logic        w_found;
    logic [1:0]  w_win;
    logic [19:0] w_add_sum;
    logic        w_add_cout;

    // The only adder in the block; it always sees the captured operands.
    twenty_bit_adder u_adder (
        .a_i    (a_q),
        .b_i    (b_q),
        .sum_o  (w_add_sum),
        .cout_o (w_add_cout)
    );

    // Round-robin search: walk offsets from high to low so the smallest
    // offset from the pointer that is valid ends up as the winner.
    always_comb begin
        logic [1:0] cand;
        w_found = 1'b0;
        w_win   = 2'd0;
        cand    = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            cand = ptr_q + 2'(i);
            if (req_valid[cand]) begin
                w_found = 1'b1;
                w_win   = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        a_d       = a_q;
        b_d       = b_q;
        id_d      = id_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        rid_d     = rid_q;
        req_ready = 4'b0000;

        case (state_q)
            S_IDLE: begin
                // Grant is suppressed during reset so nothing is accepted
                // on an edge that is about to clear the state.
                if (w_found && !rst) begin
                    req_ready = 4'b0001 << w_win;
                    a_d       = req_a[w_win*20 +: 20];
                    b_d       = req_b[w_win*20 +: 20];
                    id_d      = w_win;
                    ptr_d     = w_win + 2'd1;
                    state_d   = S_CALC;
                end
            end
            S_CALC: begin
                sum_d   = w_add_sum;
                cout_d  = w_add_cout;
                rid_d   = id_q;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= 2'd0;
            a_q     <= 20'd0;
            b_q     <= 20'd0;
            id_q    <= 2'd0;
            sum_q   <= 20'd0;
            cout_q  <= 1'b0;
            rid_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            id_q    <= id_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            rid_q   <= rid_d;
        end
    end

    assign resp_valid = (state_q == S_RESP);
    assign resp_sum   = sum_q;
    assign resp_cout  = cout_q;
    assign resp_id    = rid_q;

endmodule
`default_nettype wire
